// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 16-bit 5-stage pipeline:
// load-use stalls, control-transfer flushes, memory freezes and statistics.
module pipe_hazard_ctrl #(
    parameter int REG_AW         = 3,
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16,
    parameter int ZERO_REG_EN    = 1
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs_addr_i,
    input  logic [REG_AW-1:0] id_rt_addr_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              ex_memread_i,
    input  logic              ex_regwrite_i,
    input  logic [REG_AW-1:0] ex_dst_addr_i,
    input  logic              ex_branch_taken_i,
    input  logic              ex_jump_i,
    input  logic              mem_busy_i,
    input  logic              cnt_clr_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              dhz_o,
    output logic              chz_o,
    output logic              pipe_freeze_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYC - 1);

    state_e           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic rs_hit, rt_hit, zero_dst, luh, cth;

    assign rs_hit   = id_use_rs_i && (id_rs_addr_i == ex_dst_addr_i);
    assign rt_hit   = id_use_rt_i && (id_rt_addr_i == ex_dst_addr_i);
    assign zero_dst = (ZERO_REG_EN != 0) && (ex_dst_addr_i == '0);
    assign luh      = ex_memread_i && ex_regwrite_i
                      && (rs_hit || rt_hit) && !zero_dst;
    assign cth      = ex_branch_taken_i || ex_jump_i;

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        dhz_o         = 1'b0;
        chz_o         = 1'b0;
        pipe_freeze_o = 1'b0;
        state_d       = state_q;
        rem_d         = rem_q;

        // Priority: reset, freeze, control transfer, then data hazard.
        if (!rst_n) begin
            state_d = RUN;
            rem_d   = '0;
        end else if (mem_busy_i) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            pipe_freeze_o = 1'b1;
        end else if (cth) begin
            chz_o        = 1'b1;
            ifid_flush_o = 1'b1;
            state_d      = RUN;
            rem_d        = '0;
        end else if (state_q == STALL) begin
            dhz_o        = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            rem_d        = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (luh) begin
            dhz_o        = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            if (LOAD_STALL_CYC > 1) begin
                state_d = STALL;
                rem_d   = REM_INIT;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (dhz_o && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (chz_o && !(&flush_cnt_q)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: four configurations share one stimulus,
// each checked against a bubbles-left reference model.
module tb_pipe_hazard_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rs, rt, dst;
    logic       use_rs, use_rt, memrd, regwr, br, jmp, busy, clr;

    // {pc_write, ifid_write, ifid_flush, dhz, chz, pipe_freeze}
    logic [5:0]  o  [4];
    logic [15:0] sc [4];
    logic [15:0] fc [4];

    int checks = 0;
    int errors = 0;

    int bub [4];
    int stc [4];
    int flc [4];
    localparam int LSC_M [4] = '{1, 3, 1, 1};
    localparam int ZR_M  [4] = '{1, 1, 0, 1};
    localparam int MAX_M [4] = '{65535, 65535, 65535, 15};

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CW = (g == 3) ? 4 : 16;
        localparam int LS = (g == 1) ? 3 : 1;
        localparam int ZR = (g == 2) ? 0 : 1;
        logic [CW-1:0] s, f;
        logic pw, iw, fl, dh, ch, fr;
        pipe_hazard_ctrl #(
            .REG_AW(3), .LOAD_STALL_CYC(LS),
            .CNT_W(CW), .ZERO_REG_EN(ZR)
        ) u_dut (
            .clk_i(clk_i), .rst_n(rst_n),
            .id_rs_addr_i(rs), .id_rt_addr_i(rt),
            .id_use_rs_i(use_rs), .id_use_rt_i(use_rt),
            .ex_memread_i(memrd), .ex_regwrite_i(regwr),
            .ex_dst_addr_i(dst), .ex_branch_taken_i(br),
            .ex_jump_i(jmp), .mem_busy_i(busy), .cnt_clr_i(clr),
            .pc_write_o(pw), .ifid_write_o(iw), .ifid_flush_o(fl),
            .dhz_o(dh), .chz_o(ch), .pipe_freeze_o(fr),
            .stall_cnt_o(s), .flush_cnt_o(f)
        );
        assign o[g]  = {pw, iw, fl, dh, ch, fr};
        assign sc[g] = 16'(s);
        assign fc[g] = 16'(f);
    end

    function automatic logic luh_m(int i);
        logic hit;
        hit = (use_rs && rs == dst) || (use_rt && rt == dst);
        return memrd && regwr && hit && !(ZR_M[i] != 0 && dst == 3'd0);
    endfunction

    function automatic logic [5:0] exp_ctl(int i);
        if (!rst_n)                    return 6'b110000;
        if (busy)                      return 6'b000001;
        if (br || jmp)                 return 6'b111010;
        if (bub[i] > 0 || luh_m(i))    return 6'b000100;
        return 6'b110000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            bub[i] = 0; stc[i] = 0; flc[i] = 0;
        end
    endtask

    task automatic tick();
        logic [5:0] e;
        logic l;
        @(posedge clk_i);
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                bub[i] = 0; stc[i] = 0; flc[i] = 0;
            end else begin
                e = exp_ctl(i);
                l = luh_m(i);
                if (!busy) begin
                    if (br || jmp)      bub[i] = 0;
                    else if (bub[i] > 0) bub[i] = bub[i] - 1;
                    else if (l)         bub[i] = LSC_M[i] - 1;
                end
                if (clr) begin
                    stc[i] = 0; flc[i] = 0;
                end else begin
                    if (e[2] && stc[i] < MAX_M[i]) stc[i]++;
                    if (e[1] && flc[i] < MAX_M[i]) flc[i]++;
                end
            end
        end
        #1;
    endtask

    task automatic quiet();
        rs = 3'd0; rt = 3'd0; dst = 3'd0;
        use_rs = 0; use_rt = 0; memrd = 0; regwr = 0;
        br = 0; jmp = 0; busy = 0; clr = 0;
    endtask

    task automatic set_lu(input logic [2:0] d, input logic [2:0] r);
        quiet();
        memrd = 1; regwr = 1; dst = d; rs = r; use_rs = 1;
    endtask

    task automatic clr_cnt();
        quiet();
        clr = 1;
        repeat (4) tick();
        clr = 0;
    endtask

    task automatic test_reset();
        quiet();
        model_reset();
        #3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o[i] !== 6'b110000 || sc[i] !== 16'd0 || fc[i] !== 16'd0) begin
                errors++;
                $display("FAIL reset dut%0d ctl=%b want 110000 stall=%0d flush=%0d want 0",
                         i, o[i], sc[i], fc[i]);
            end
        end
        @(negedge clk_i);
        rst_n = 1;
        tick();
    endtask

    task automatic test_load_use_1();
        clr_cnt();
        set_lu(3'd3, 3'd3);
        @(negedge clk_i);
        checks++;
        if (o[0] !== 6'b000100) begin
            errors++;
            $display("FAIL lu1_bubble ctl=%b want 000100", o[0]);
        end
        tick();
        quiet();
        use_rs = 1; rs = 3'd3;
        @(negedge clk_i);
        checks++;
        if (o[0] !== 6'b110000 || sc[0] !== 16'd1) begin
            errors++;
            $display("FAIL lu1_release ctl=%b want 110000 stall=%0d want 1", o[0], sc[0]);
        end
        tick();
    endtask

    task automatic test_load_use_3_freeze();
        logic [5:0] dz = 6'b011001;
        logic [5:0] fz = 6'b000110;
        int nd = 0;
        int nf = 0;
        clr_cnt();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) set_lu(3'd3, 3'd3);
            else quiet();
            busy = (c == 1 || c == 2);
            @(negedge clk_i);
            nd += int'(o[1][2]);
            nf += int'(o[1][0]);
            checks++;
            if (o[1][2] !== dz[c] || o[1][0] !== fz[c]) begin
                errors++;
                $display("FAIL lu3_cycle%0d dhz=%b frz=%b want %b %b",
                         c, o[1][2], o[1][0], dz[c], fz[c]);
            end
            if (c == 5) begin
                checks++;
                if (nd != 3 || nf != 2 || sc[1] !== 16'd3) begin
                    errors++;
                    $display("FAIL lu3_totals dhz=%0d frz=%0d stall=%0d want 3 2 3",
                             nd, nf, sc[1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_ctrl_vs_data();
        clr_cnt();
        set_lu(3'd3, 3'd3);
        br = 1;
        @(negedge clk_i);
        checks++;
        if (o[0] !== 6'b111010) begin
            errors++;
            $display("FAIL ctrl_wins ctl=%b want 111010", o[0]);
        end
        tick();
        quiet();
        @(negedge clk_i);
        checks++;
        if (fc[0] !== 16'd1 || sc[0] !== 16'd0) begin
            errors++;
            $display("FAIL ctrl_cnt flush=%0d stall=%0d want 1 0", fc[0], sc[0]);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        clr_cnt();
        set_lu(3'd0, 3'd0);
        @(negedge clk_i);
        checks++;
        if (o[0][2] !== 1'b0 || o[2][2] !== 1'b1) begin
            errors++;
            $display("FAIL zero_reg dhz_zr1=%b want 0 dhz_zr0=%b want 1",
                     o[0][2], o[2][2]);
        end
        tick();
        quiet();
        @(negedge clk_i);
        checks++;
        if (sc[0] !== 16'd0 || sc[2] !== 16'd1) begin
            errors++;
            $display("FAIL zero_cnt stall_zr1=%0d want 0 stall_zr0=%0d want 1",
                     sc[0], sc[2]);
        end
        tick();
    endtask

    task automatic test_saturate();
        clr_cnt();
        jmp = 1;
        repeat (20) tick();
        @(negedge clk_i);
        checks++;
        if (fc[3] !== 16'd15 || fc[0] !== 16'd20) begin
            errors++;
            $display("FAIL saturate flush4=%0d want 15 flush16=%0d want 20",
                     fc[3], fc[0]);
        end
        clr = 1;
        tick();
        clr = 0;
        @(negedge clk_i);
        checks++;
        if (fc[3] !== 16'd0 || fc[0] !== 16'd0) begin
            errors++;
            $display("FAIL clr_wins flush4=%0d flush16=%0d want 0", fc[3], fc[0]);
        end
        tick();
        quiet();
    endtask

    task automatic test_reset_mid_stall();
        clr_cnt();
        set_lu(3'd3, 3'd3);
        @(negedge clk_i);
        tick();
        quiet();
        @(negedge clk_i);
        checks++;
        if (o[1] !== 6'b000100) begin
            errors++;
            $display("FAIL mid_stall ctl=%b want 000100", o[1]);
        end
        #1 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (o[1] !== 6'b110000 || sc[1] !== 16'd0) begin
            errors++;
            $display("FAIL async_rst ctl=%b want 110000 stall=%0d want 0", o[1], sc[1]);
        end
        @(posedge clk_i);
        #2 rst_n = 1;
        use_rs = 1; rs = 3'd2;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            checks++;
            if (o[1] !== 6'b110000) begin
                errors++;
                $display("FAIL post_rst%0d ctl=%b want 110000", c, o[1]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            set_lu(3'd5, 3'd5);
            use_rt = 1; rt = 3'd5; use_rs = 0;
            br = (c == 6);
            @(negedge clk_i);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (o[i] !== exp_ctl(i) || sc[i] !== 16'(stc[i])) begin
                    errors++;
                    $display("FAIL b2b c%0d dut%0d ctl=%b want %b stall=%0d want %0d",
                             c, i, o[i], exp_ctl(i), sc[i], stc[i]);
                end
            end
            tick();
        end
        quiet();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rs     = 3'($urandom_range(0, 7));
            rt     = 3'($urandom_range(0, 7));
            dst    = 3'($urandom_range(0, 7));
            use_rs = 1'($urandom_range(0, 1));
            use_rt = 1'($urandom_range(0, 1));
            memrd  = ($urandom_range(0, 99) < 60);
            regwr  = ($urandom_range(0, 99) < 80);
            br     = ($urandom_range(0, 99) < 10);
            jmp    = ($urandom_range(0, 99) < 5);
            busy   = ($urandom_range(0, 99) < 15);
            clr    = ($urandom_range(0, 99) < 3);
            @(negedge clk_i);
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (o[i] !== exp_ctl(i) || sc[i] !== 16'(stc[i])
                    || fc[i] !== 16'(flc[i])) begin
                    errors++;
                    $display("FAIL rand c%0d dut%0d ctl=%b want %b stall=%0d want %0d flush=%0d want %0d",
                             c, i, o[i], exp_ctl(i), sc[i], stc[i], fc[i], flc[i]);
                end
            end
            tick();
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_load_use_1();
        test_load_use_3_freeze();
        test_ctrl_vs_data();
        test_zero_reg();
        test_saturate();
        test_reset_mid_stall();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 16-bit 5-stage pipeline.
- Detects load-use data hazards between the ID and EX stages, and control transfers resolved in EX.
- Detects memory-wait freezes.
- Drives PC write-enable, IF/ID write/flush, and the DHZ/CHZ bubble inputs of the ID/EX pipeline register.
- Provides saturating stall and flush statistics counters for performance debug.

Parameters:
REG_AW, 3, register address width (rs/rt/rd fields)
LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 16, width of stall/flush statistics counters
ZERO_REG_EN, 1, 1 = register 0 is hard-wired zero and never creates a hazard

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs_addr_i  in  REG_AW  rs address of instruction in ID
id_rt_addr_i  in  REG_AW  rt address of instruction in ID
id_use_rs_i  in  1  ID instruction reads rs
id_use_rt_i  in  1  ID instruction reads rt
ex_memread_i  in  1  memRead bit of ID/EX MEM field
ex_regwrite_i  in  1  regWrite bit of ID/EX WB field
ex_dst_addr_i  in  REG_AW  destination register of EX instruction
ex_branch_taken_i  in  1  branch in EX resolved taken
ex_jump_i  in  1  jump in EX
mem_busy_i  in  1  data memory not ready; whole pipe must hold
cnt_clr_i  in  1  synchronous clear of statistics counters
pc_write_o  out  1  PC register load enable
ifid_write_o  out  1  IF/ID register load enable
ifid_flush_o  out  1  IF/ID loads NOP
dhz_o  out  1  to ID/EX DHZ_i (bubble control fields)
chz_o  out  1  to ID/EX CHZ_i (bubble control fields)
pipe_freeze_o  out  1  hold all pipeline registers this cycle
stall_cnt_o  out  CNT_W  cycles with dhz_o=1, saturating
flush_cnt_o  out  CNT_W  cycles with chz_o=1, saturating

Behaviour:
- Reset is async and active-low. Clock is clk_i.
- Registered state: FSM state, 3-bit bubble counter rem, stall_cnt, flush_cnt. All reset to RUN, 0, 0, 0.
- Outputs are a Mealy decode of state and current inputs; there is no added latency. Outputs in reset: pc_write_o=1, ifid_write_o=1, all others 0.
- luh (load-use hit) = ex_memread_i & ex_regwrite_i & ((id_use_rs_i & rs==dst) | (id_use_rt_i & rt==dst)) & !(ZERO_REG_EN & dst==0).
- cth (control-transfer hit) = ex_branch_taken_i | ex_jump_i.
- Priority, evaluated every cycle: FREEZE > control > data.
- FREEZE (mem_busy_i=1), any state:
  - pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, dhz_o=0, chz_o=0, pipe_freeze_o=1.
  - State and rem hold. Counters do not increment.
- State RUN:
  - cth: chz_o=1, ifid_flush_o=1, pc_write_o=1, ifid_write_o=1. Stay in RUN.
  - else luh: dhz_o=1, pc_write_o=0, ifid_write_o=0. If LOAD_STALL_CYC>1, go to STALL with rem=LOAD_STALL_CYC-1; else stay in RUN.
  - else: pc_write_o=1, ifid_write_o=1, all hazard outputs 0.
- State STALL:
  - dhz_o=1, pc_write_o=0, ifid_write_o=0. rem decrements each non-frozen cycle.
  - When rem==1 in the current cycle, next state is RUN.
  - cth in STALL (abnormal): control path wins. Outputs as RUN+cth, rem cleared, next state RUN.
- dhz_o and chz_o are never both 1. ifid_flush_o=1 only with chz_o=1.
- Counters:
  - +1 per cycle the respective output is 1; saturate at all-ones, no wrap.
  - cnt_clr_i=1 forces both counters to 0 next edge; clear wins over increment.
- Reset asserted mid-STALL: state returns to RUN immediately (async). Counters clear.

Test Plan:
1. Load-use, LOAD_STALL_CYC=1. EX lw dst=3, ID add rs=3 use_rs=1 -> dhz_o=1, pc_write_o=0, ifid_write_o=0 for exactly 1 cycle; stall_cnt_o=1.
2. LOAD_STALL_CYC=3, same hazard, with mem_busy_i=1 for 2 cycles during the 2nd bubble -> dhz_o high for 3 non-frozen cycles (5 total cycles); pipe_freeze_o=1 only for those 2 cycles; stall_cnt_o=3.
3. Load-use and taken branch asserted in the same cycle -> chz_o=1, ifid_flush_o=1, dhz_o=0, pc_write_o=1; flush_cnt_o=1, stall_cnt_o=0.
4. ZERO_REG_EN=1: lw dst=0, ID rs=0 -> no stall. ZERO_REG_EN=0: same stimulus -> 1 bubble.
5. CNT_W=4: 20 jumps in a row -> flush_cnt_o holds at 15. Pulse cnt_clr_i while a jump is present -> flush_cnt_o=0 next cycle.
6. Assert rst_n=0 in the 2nd cycle of a 3-cycle STALL -> outputs return to reset values immediately; after release, a normal instruction gives pc_write_o=1, ifid_write_o=1.
